// File: rtl/snow64_mem_req_queue.sv
// In-order request FIFO between the LAR file and the memory bus guard's data ports.
// Issues one request at a time, holds it until accepted, then returns a one-cycle completion.
module snow64_mem_req_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_req_valid,
  input  logic              in_req_is_write,
  input  logic [ADDR_W-1:0] in_req_addr,
  input  logic [DATA_W-1:0] in_req_data,
  output logic              out_req_ready,
  output logic              out_guard_rd_req,
  output logic              out_guard_wr_req,
  output logic [ADDR_W-1:0] out_guard_addr,
  output logic [DATA_W-1:0] out_guard_wr_data,
  input  logic              in_guard_rd_valid,
  input  logic              in_guard_rd_cmd_accepted,
  input  logic [DATA_W-1:0] in_guard_rd_data,
  input  logic              in_guard_wr_valid,
  input  logic              in_guard_wr_cmd_accepted,
  output logic              out_done_valid,
  output logic              out_done_is_write,
  output logic [DATA_W-1:0] out_done_data,
  output logic              out_busy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone
  } stateT;

  stateT              state;
  logic [PtrW-1:0]    wrPtr;
  logic [PtrW-1:0]    rdPtr;
  logic [CntW-1:0]    count;
  logic               curIsWrite;

  logic               memIsWrite [DEPTH];
  logic [ADDR_W-1:0]  memAddr    [DEPTH];
  logic [DATA_W-1:0]  memData    [DEPTH];

  logic               headIsWrite;
  logic               issuing;
  logic               doPush;
  logic               headAccepted;
  logic               headValid;
  logic               curValid;

  // Ready depends only on registered count, so a same-cycle pop never opens a slot early.
  assign out_req_ready = (count != CntW'(DEPTH));
  assign doPush        = in_req_valid && out_req_ready;
  assign out_busy      = (count != '0) || (state != StIdle);

  // Guard-facing decode of the registered state and FIFO head; held steady through StIssue.
  assign headIsWrite       = memIsWrite[rdPtr];
  assign issuing           = (state == StIssue);
  assign out_guard_rd_req  = issuing && !headIsWrite;
  assign out_guard_wr_req  = issuing && headIsWrite;
  assign out_guard_addr    = issuing ? memAddr[rdPtr] : '0;
  assign out_guard_wr_data = (issuing && headIsWrite) ? memData[rdPtr] : '0;

  // Only the port matching the request in flight is listened to.
  assign headAccepted = issuing &&
                        (headIsWrite ? in_guard_wr_cmd_accepted : in_guard_rd_cmd_accepted);
  assign headValid    = headIsWrite ? in_guard_wr_valid : in_guard_rd_valid;
  assign curValid     = curIsWrite ? in_guard_wr_valid : in_guard_rd_valid;

  // Payload storage; contents are don't-care until pushed, so no reset needed.
  always_ff @(posedge clk) begin
    if (doPush) begin
      memIsWrite[wrPtr] <= in_req_is_write;
      memAddr[wrPtr]    <= in_req_addr;
      memData[wrPtr]    <= in_req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= StIdle;
      wrPtr             <= '0;
      rdPtr             <= '0;
      count             <= '0;
      curIsWrite        <= 1'b0;
      out_done_valid    <= 1'b0;
      out_done_is_write <= 1'b0;
      out_done_data     <= '0;
    end else begin
      out_done_valid    <= 1'b0;
      out_done_is_write <= 1'b0;
      out_done_data     <= '0;

      if (doPush) wrPtr <= wrPtr + PtrW'(1);
      if (headAccepted) rdPtr <= rdPtr + PtrW'(1);

      case ({doPush, headAccepted})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase

      case (state)
        StIdle: begin
          if (count != '0) state <= StIssue;
        end
        StIssue: begin
          if (headAccepted) begin
            curIsWrite <= headIsWrite;
            if (headValid) begin
              out_done_valid    <= 1'b1;
              out_done_is_write <= headIsWrite;
              out_done_data     <= headIsWrite ? '0 : in_guard_rd_data;
              state             <= StIdle;
            end else begin
              state <= StWaitDone;
            end
          end
        end
        StWaitDone: begin
          if (curValid) begin
            out_done_valid    <= 1'b1;
            out_done_is_write <= curIsWrite;
            out_done_data     <= curIsWrite ? '0 : in_guard_rd_data;
            state             <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_snow64_mem_req_queue.sv
// Directed bench for snow64_mem_req_queue: inputs change on the falling edge,
// outputs are sampled on the falling edge, expectations are hand-computed.
module tb_snow64_mem_req_queue;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_req_valid;
  logic         in_req_is_write;
  logic [63:0]  in_req_addr;
  logic [255:0] in_req_data;
  logic         out_req_ready;
  logic         out_guard_rd_req;
  logic         out_guard_wr_req;
  logic [63:0]  out_guard_addr;
  logic [255:0] out_guard_wr_data;
  logic         in_guard_rd_valid;
  logic         in_guard_rd_cmd_accepted;
  logic [255:0] in_guard_rd_data;
  logic         in_guard_wr_valid;
  logic         in_guard_wr_cmd_accepted;
  logic         out_done_valid;
  logic         out_done_is_write;
  logic [255:0] out_done_data;
  logic         out_busy;

  int nTests = 0;
  int nFail  = 0;

  localparam logic [255:0] Noise = {8{32'hDEAD_BEEF}};

  snow64_mem_req_queue #(.DEPTH(4), .ADDR_W(64), .DATA_W(256)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .in_req_valid             (in_req_valid),
    .in_req_is_write          (in_req_is_write),
    .in_req_addr              (in_req_addr),
    .in_req_data              (in_req_data),
    .out_req_ready            (out_req_ready),
    .out_guard_rd_req         (out_guard_rd_req),
    .out_guard_wr_req         (out_guard_wr_req),
    .out_guard_addr           (out_guard_addr),
    .out_guard_wr_data        (out_guard_wr_data),
    .in_guard_rd_valid        (in_guard_rd_valid),
    .in_guard_rd_cmd_accepted (in_guard_rd_cmd_accepted),
    .in_guard_rd_data         (in_guard_rd_data),
    .in_guard_wr_valid        (in_guard_wr_valid),
    .in_guard_wr_cmd_accepted (in_guard_wr_cmd_accepted),
    .out_done_valid           (out_done_valid),
    .out_done_is_write        (out_done_is_write),
    .out_done_data            (out_done_data),
    .out_busy                 (out_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic setPush(input logic isW, input logic [63:0] addr, input logic [255:0] data);
    in_req_valid    = 1'b1;
    in_req_is_write = isW;
    in_req_addr     = addr;
    in_req_data     = data;
  endtask

  // Waits for the next request, accepts it, completes it, and checks the done pulse.
  task automatic serviceOne(input logic isW, input logic [63:0] addr, input logic [255:0] wdata,
                            input logic same, input logic [255:0] rdData);
    logic found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (out_guard_rd_req || out_guard_wr_req) found = 1'b1;
    end
    check("reqSeen", 256'(found), 256'(1'b1));
    if (!found) return;
    check("reqType", 256'({out_guard_wr_req, out_guard_rd_req}), 256'(isW ? 2'b10 : 2'b01));
    check("reqAddr", 256'(out_guard_addr), 256'(addr));
    if (isW) check("reqWrData", out_guard_wr_data, wdata);
    in_guard_rd_data = rdData;
    if (isW) in_guard_wr_cmd_accepted = 1'b1; else in_guard_rd_cmd_accepted = 1'b1;
    if (same) begin
      if (isW) in_guard_wr_valid = 1'b1; else in_guard_rd_valid = 1'b1;
    end
    @(negedge clk);
    in_guard_wr_cmd_accepted = 1'b0;
    in_guard_rd_cmd_accepted = 1'b0;
    in_guard_wr_valid = 1'b0;
    in_guard_rd_valid = 1'b0;
    check("reqDrop", 256'({out_guard_wr_req, out_guard_rd_req}), 256'(2'b00));
    if (!same) begin
      check("doneEarly", 256'(out_done_valid), 256'(1'b0));
      if (isW) in_guard_wr_valid = 1'b1; else in_guard_rd_valid = 1'b1;
      @(negedge clk);
      in_guard_wr_valid = 1'b0;
      in_guard_rd_valid = 1'b0;
    end
    check("doneValid", 256'(out_done_valid), 256'(1'b1));
    check("doneIsWrite", 256'(out_done_is_write), 256'(isW));
    check("doneData", out_done_data, isW ? 256'(0) : rdData);
    @(negedge clk);
    check("donePulse", 256'(out_done_valid), 256'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with hostile inputs
    rst_n = 1'b0;
    setPush(1'b1, 64'h1, Noise);
    in_guard_rd_valid = 1'b1; in_guard_rd_cmd_accepted = 1'b1;
    in_guard_wr_valid = 1'b1; in_guard_wr_cmd_accepted = 1'b1;
    in_guard_rd_data = Noise;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rstDone", 256'(out_done_valid), 256'(1'b0));
      check("rstReq", 256'({out_guard_wr_req, out_guard_rd_req}), 256'(2'b00));
      check("rstAddr", 256'(out_guard_addr), 256'(0));
      check("rstReady", 256'(out_req_ready), 256'(1'b1));
      check("rstBusy", 256'(out_busy), 256'(1'b0));
    end
    rst_n = 1'b1;
    in_req_valid = 1'b0;
    in_guard_rd_valid = 1'b0; in_guard_rd_cmd_accepted = 1'b0;
    in_guard_wr_valid = 1'b0; in_guard_wr_cmd_accepted = 1'b0;
    @(negedge clk);
    check("postRstBusy", 256'(out_busy), 256'(1'b0));

    // Single read: push cycle 0, accept cycle 4, valid cycle 6, done cycle 7
    setPush(1'b0, 64'h1000, Noise);
    check("c0RdReq", 256'(out_guard_rd_req), 256'(1'b0));
    @(negedge clk);
    in_req_valid = 1'b0;
    check("c1RdReq", 256'(out_guard_rd_req), 256'(1'b0));
    check("c1Busy", 256'(out_busy), 256'(1'b1));
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      check("c2to4RdReq", 256'(out_guard_rd_req), 256'(1'b1));
      check("c2to4WrReq", 256'(out_guard_wr_req), 256'(1'b0));
      check("c2to4Addr", 256'(out_guard_addr), 256'(64'h1000));
    end
    in_guard_rd_cmd_accepted = 1'b1;
    @(negedge clk);
    in_guard_rd_cmd_accepted = 1'b0;
    check("c5RdReq", 256'(out_guard_rd_req), 256'(1'b0));
    in_guard_wr_valid = 1'b1;
    @(negedge clk);
    in_guard_wr_valid = 1'b0;
    check("c6WrongValid", 256'(out_done_valid), 256'(1'b0));
    in_guard_rd_valid = 1'b1;
    in_guard_rd_data = {32{8'hA5}};
    @(negedge clk);
    in_guard_rd_valid = 1'b0;
    check("c7Done", 256'(out_done_valid), 256'(1'b1));
    check("c7Data", out_done_data, {32{8'hA5}});
    check("c7IsWrite", 256'(out_done_is_write), 256'(1'b0));
    @(negedge clk);
    check("c8Done", 256'(out_done_valid), 256'(1'b0));
    check("c8Busy", 256'(out_busy), 256'(1'b0));

    // Fill and overflow: five writes, fifth dropped
    for (int i = 0; i < 5; i++) begin
      check("fillReady", 256'(out_req_ready), 256'(i < 4));
      setPush(1'b1, 64'(i * 32'h20), 256'(i + 32'h100));
      @(negedge clk);
    end
    in_req_valid = 1'b0;
    check("fullReady", 256'(out_req_ready), 256'(1'b0));
    for (int i = 0; i < 4; i++)
      serviceOne(1'b1, 64'(i * 32'h20), 256'(i + 32'h100), 1'b0, Noise);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("noFifthReq", 256'({out_guard_wr_req, out_guard_rd_req}), 256'(2'b00));
    end
    check("fillBusy", 256'(out_busy), 256'(1'b0));

    // Same-cycle accept+valid, then queued read issues two cycles after accept
    setPush(1'b1, 64'h2000, 256'h77);
    @(negedge clk);
    setPush(1'b0, 64'h3000, Noise);
    @(negedge clk);
    in_req_valid = 1'b0;
    serviceOne(1'b1, 64'h2000, 256'h77, 1'b1, Noise);
    check("nextIssueRd", 256'(out_guard_rd_req), 256'(1'b1));
    check("nextIssueAddr", 256'(out_guard_addr), 256'(64'h3000));
    serviceOne(1'b0, 64'h3000, 256'(0), 1'b0, {16{16'h5A3C}});

    // Full queue: push held through the accept cycle is taken once a slot frees
    for (int i = 1; i <= 4; i++) begin
      check("pfReady", 256'(out_req_ready), 256'(1'b1));
      setPush(1'b0, 64'(i * 32'h100), Noise);
      @(negedge clk);
    end
    setPush(1'b0, 64'h500, Noise);
    check("pfFullReady", 256'(out_req_ready), 256'(1'b0));
    check("pfHeadAddr", 256'(out_guard_addr), 256'(64'h100));
    in_guard_rd_cmd_accepted = 1'b1;
    @(negedge clk);
    in_guard_rd_cmd_accepted = 1'b0;
    check("pfFreedReady", 256'(out_req_ready), 256'(1'b1));
    in_guard_rd_valid = 1'b1;
    in_guard_rd_data = 256'h1;
    @(negedge clk);
    in_req_valid = 1'b0;
    in_guard_rd_valid = 1'b0;
    check("pfRefillReady", 256'(out_req_ready), 256'(1'b0));
    check("pfDone1", 256'(out_done_valid), 256'(1'b1));
    check("pfData1", out_done_data, 256'h1);
    for (int i = 2; i <= 5; i++)
      serviceOne(1'b0, 64'(i * 32'h100), 256'(0), 1'b0, 256'(i));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("pfNoExtra", 256'({out_guard_wr_req, out_guard_rd_req}), 256'(2'b00));
    end

    // Reset while waiting for valid
    setPush(1'b0, 64'h600, Noise);
    @(negedge clk);
    in_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midRdReq", 256'(out_guard_rd_req), 256'(1'b1));
    in_guard_rd_cmd_accepted = 1'b1;
    @(negedge clk);
    in_guard_rd_cmd_accepted = 1'b0;
    check("midBusy", 256'(out_busy), 256'(1'b1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_guard_rd_valid = 1'b1;
    in_guard_rd_data = Noise;
    @(negedge clk);
    in_guard_rd_valid = 1'b0;
    check("midNoDone", 256'(out_done_valid), 256'(1'b0));
    check("midIdleBusy", 256'(out_busy), 256'(1'b0));
    @(negedge clk);
    check("midNoDoneLate", 256'(out_done_valid), 256'(1'b0));

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
